playback_sequencer: RTL and testbench

//  Plays back a recorded keypad sequence. Steps the 12-slot note SRAM from address 0 upward.
//  For each slot: reads the stored 4-bit note code, drives it to the PianoPlay tone generator
//  for a fixed note time, then holds a silent gap. Owns the SRAM address/RW port while busy.

---
 rtl/playback_sequencer.sv | 154 +++++++++++++++
 tb/tb_playback_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/playback_sequencer.sv
// Plays back a recorded keypad sequence from the 12-slot note SRAM to the PianoPlay tone generator.
// Optional `define LOOP_PLAY_EN: at end of memory restart from address 0 instead of going idle.
module playback_sequencer #(
  parameter int DEPTH      = 12,
  parameter int ADDR_W     = 4,
  parameter int NOTE_TICKS = 1000000,
  parameter int GAP_TICKS  = 100000,
  parameter int CNT_W      = 24
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Start,
  input  logic              Stop,
  input  logic [3:0]        Sram_Dout,
  output logic [ADDR_W-1:0] Sram_Addr,
  output logic              Sram_Rd,
  output logic [3:0]        Bin,
  output logic              EN,
  output logic              Busy
);

  localparam logic [3:0] END_CODE = 4'd12;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    LATCH = 3'd3,
    PLAY  = 3'd4,
    GAP   = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_q, rd_d;
  logic [3:0]        bin_q, bin_d;
  logic              en_q, en_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        code_q, code_d;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      bin_q   <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      bin_q   <= bin_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  // Captured SRAM code is pure data; it is only consumed in LATCH after being written in WAIT.
  always_ff @(posedge CLK) begin
    code_q <= code_d;
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rd_d    = 1'b0;
    bin_d   = bin_q;
    en_d    = en_q;
    cnt_d   = cnt_q;
    code_d  = code_q;

    if (Stop) begin
      state_d = IDLE;
      addr_d  = '0;
      en_d    = 1'b0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (Start) begin
            state_d = FETCH;
            addr_d  = '0;
            rd_d    = 1'b1;
          end
        end
        FETCH: state_d = WAIT;
        WAIT: begin
          code_d  = Sram_Dout;
          state_d = LATCH;
        end
        LATCH: begin
          if (code_q >= END_CODE) begin
            state_d = IDLE;
            addr_d  = '0;
            en_d    = 1'b0;
            cnt_d   = '0;
          end else begin
            state_d = PLAY;
            bin_d   = code_q;
            en_d    = 1'b1;
            cnt_d   = CNT_W'(NOTE_TICKS - 1);
          end
        end
        PLAY: begin
          if (cnt_q == '0) begin
            state_d = GAP;
            en_d    = 1'b0;
            cnt_d   = CNT_W'(GAP_TICKS - 1);
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        GAP: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else if (addr_q != ADDR_W'(DEPTH - 1)) begin
            state_d = FETCH;
            addr_d  = addr_q + ADDR_W'(1);
            rd_d    = 1'b1;
          end else begin
`ifdef LOOP_PLAY_EN
            state_d = FETCH;
            addr_d  = '0;
            rd_d    = 1'b1;
`else
            state_d = IDLE;
            addr_d  = '0;
            cnt_d   = '0;
`endif
          end
        end
        default: begin
          state_d = IDLE;
          addr_d  = '0;
          en_d    = 1'b0;
          cnt_d   = '0;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  assign Sram_Addr = addr_q;
  assign Sram_Rd   = rd_q;
  assign Bin       = bin_q;
  assign EN        = en_q;
  assign Busy      = busy_q;

endmodule

// File: tb/tb_playback_sequencer.sv
// Directed bench for playback_sequencer with NOTE_TICKS=4, GAP_TICKS=2, DEPTH=12 and a 1-cycle SRAM model.
module tb_playback_sequencer;

  logic       CLK = 1'b0;
  logic       RST;
  logic       Start;
  logic       Stop;
  logic [3:0] Sram_Dout;
  logic [3:0] Sram_Addr;
  logic       Sram_Rd;
  logic [3:0] Bin;
  logic       EN;
  logic       Busy;

  logic [3:0] mem [0:15];

  int vectors    = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (Sram_Rd) Sram_Dout <= mem[Sram_Addr];
  end

  playback_sequencer #(
    .DEPTH(12), .ADDR_W(4), .NOTE_TICKS(4), .GAP_TICKS(2), .CNT_W(8)
  ) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .Stop(Stop), .Sram_Dout(Sram_Dout),
    .Sram_Addr(Sram_Addr), .Sram_Rd(Sram_Rd), .Bin(Bin), .EN(EN), .Busy(Busy)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic fill(input logic [3:0] v);
    for (int i = 0; i < 16; i++) mem[i] = v;
  endtask

  task automatic test_reset();
    RST = 1'b0; Start = 1'b0; Stop = 1'b0; Sram_Dout = 4'd0;
    fill(4'd5);
    repeat (2) step();
    vectors++; if (EN !== 1'b0) begin miscompares++; $display("FAIL reset_en got=%b exp=0", EN); end
    vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", Busy); end
    vectors++; if (Sram_Addr !== 4'd0) begin miscompares++; $display("FAIL reset_addr got=%0d exp=0", Sram_Addr); end
    vectors++; if (Bin !== 4'd0) begin miscompares++; $display("FAIL reset_bin got=%0d exp=0", Bin); end
    vectors++; if (Sram_Rd !== 1'b0) begin miscompares++; $display("FAIL reset_rd got=%b exp=0", Sram_Rd); end
    #2 RST = 1'b1;
    step();
    Start = 1'b1; step(); Start = 1'b0;
    repeat (4) step();
    vectors++; if (EN !== 1'b1) begin miscompares++; $display("FAIL reset_pre_play_en got=%b exp=1", EN); end
    #2 RST = 1'b0;
    #1;
    vectors++; if (EN !== 1'b0) begin miscompares++; $display("FAIL reset_async_en got=%b exp=0", EN); end
    vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL reset_async_busy got=%b exp=0", Busy); end
    vectors++; if (Sram_Addr !== 4'd0) begin miscompares++; $display("FAIL reset_async_addr got=%0d exp=0", Sram_Addr); end
    vectors++; if (Bin !== 4'd0) begin miscompares++; $display("FAIL reset_async_bin got=%0d exp=0", Bin); end
    step();
    #2 RST = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      vectors++; if (Busy !== 1'b0 || EN !== 1'b0) begin miscompares++; $display("FAIL reset_stay_idle cyc=%0d busy=%b en=%b exp=0/0", i, Busy, EN); end
    end
  endtask

  task automatic test_two_notes_end_marker();
    logic [3:0] codes [0:1];
    codes[0] = 4'd3; codes[1] = 4'd7;
    fill(4'd0);
    mem[0] = 4'd3; mem[1] = 4'd7; mem[2] = 4'd12;
    Start = 1'b1; step(); Start = 1'b0;
    for (int s = 0; s < 2; s++) begin
      for (int c = 1; c <= 9; c++) begin
        if (!(s == 0 && c == 1)) step();
        vectors++; if (EN !== ((c >= 4 && c <= 7) ? 1'b1 : 1'b0)) begin miscompares++; $display("FAIL song_en slot=%0d cyc=%0d got=%b exp=%b", s, c, EN, (c >= 4 && c <= 7)); end
        vectors++; if (Busy !== 1'b1) begin miscompares++; $display("FAIL song_busy slot=%0d cyc=%0d got=%b exp=1", s, c, Busy); end
        vectors++; if (Sram_Rd !== ((c == 1) ? 1'b1 : 1'b0)) begin miscompares++; $display("FAIL song_rd slot=%0d cyc=%0d got=%b exp=%b", s, c, Sram_Rd, (c == 1)); end
        vectors++; if (Sram_Addr !== 4'(s)) begin miscompares++; $display("FAIL song_addr slot=%0d cyc=%0d got=%0d exp=%0d", s, c, Sram_Addr, s); end
        if (c >= 4) begin
          vectors++; if (Bin !== codes[s]) begin miscompares++; $display("FAIL song_bin slot=%0d cyc=%0d got=%0d exp=%0d", s, c, Bin, codes[s]); end
        end
      end
    end
    step();
    vectors++; if (Sram_Rd !== 1'b1 || Sram_Addr !== 4'd2) begin miscompares++; $display("FAIL song_marker_fetch rd=%b addr=%0d exp=1/2", Sram_Rd, Sram_Addr); end
    repeat (2) step();
    vectors++; if (Busy !== 1'b1) begin miscompares++; $display("FAIL song_marker_latch_busy got=%b exp=1", Busy); end
    step();
    vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL song_end_busy got=%b exp=0", Busy); end
    vectors++; if (EN !== 1'b0) begin miscompares++; $display("FAIL song_end_en got=%b exp=0", EN); end
    vectors++; if (Sram_Addr !== 4'd0) begin miscompares++; $display("FAIL song_end_addr got=%0d exp=0", Sram_Addr); end
    vectors++; if (Bin !== 4'd7) begin miscompares++; $display("FAIL song_end_bin got=%0d exp=7", Bin); end
  endtask

  task automatic test_full_memory();
    int n = 0; int pulses = 0; int bad = 0; int run = 0; int addr_over = 0;
    logic prev_en = 1'b0;
    fill(4'd5);
    step();
    Start = 1'b1; step(); Start = 1'b0;
`ifdef LOOP_PLAY_EN
    for (n = 1; n <= 108; n++) begin
      step();
      if (Sram_Addr > 4'd11) addr_over++;
      if (EN) run++;
      if (prev_en && !EN) begin pulses++; if (run != 4) bad++; run = 0; end
      prev_en = EN;
    end
    vectors++; if (Busy !== 1'b1) begin miscompares++; $display("FAIL loop_busy got=%b exp=1", Busy); end
    vectors++; if (Sram_Rd !== 1'b1 || Sram_Addr !== 4'd0) begin miscompares++; $display("FAIL loop_refetch rd=%b addr=%0d exp=1/0", Sram_Rd, Sram_Addr); end
    vectors++; if (pulses !== 12 || bad !== 0) begin miscompares++; $display("FAIL loop_pulses got=%0d bad=%0d exp=12/0", pulses, bad); end
    repeat (5) step();
    vectors++; if (EN !== 1'b1 || Bin !== 4'd5) begin miscompares++; $display("FAIL loop_continue en=%b bin=%0d exp=1/5", EN, Bin); end
    Stop = 1'b1; step(); Stop = 1'b0;
    vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL loop_stop_busy got=%b exp=0", Busy); end
`else
    while (Busy && n < 300) begin
      step();
      n++;
      if (Sram_Addr > 4'd11) addr_over++;
      if (EN) run++;
      if (prev_en && !EN) begin pulses++; if (run != 4) bad++; run = 0; end
      prev_en = EN;
    end
    vectors++; if (n !== 108) begin miscompares++; $display("FAIL full_busy_fall got=%0d exp=108", n); end
    vectors++; if (pulses !== 12) begin miscompares++; $display("FAIL full_pulse_count got=%0d exp=12", pulses); end
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL full_pulse_width bad=%0d exp=0", bad); end
    vectors++; if (Sram_Addr !== 4'd0) begin miscompares++; $display("FAIL full_end_addr got=%0d exp=0", Sram_Addr); end
`endif
    vectors++; if (addr_over !== 0) begin miscompares++; $display("FAIL full_addr_range over=%0d exp=0", addr_over); end
  endtask

  task automatic test_stop();
    fill(4'd12);
    mem[0] = 4'd2; mem[1] = 4'd9;
    step();
    Start = 1'b1; step(); Start = 1'b0;
    repeat (13) step();
    vectors++; if (EN !== 1'b1 || Bin !== 4'd9 || Sram_Addr !== 4'd1) begin miscompares++; $display("FAIL stop_pre en=%b bin=%0d addr=%0d exp=1/9/1", EN, Bin, Sram_Addr); end
    Stop = 1'b1; step(); Stop = 1'b0;
    vectors++; if (EN !== 1'b0) begin miscompares++; $display("FAIL stop_en got=%b exp=0", EN); end
    vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL stop_busy got=%b exp=0", Busy); end
    vectors++; if (Sram_Addr !== 4'd0) begin miscompares++; $display("FAIL stop_addr got=%0d exp=0", Sram_Addr); end
    vectors++; if (Bin !== 4'd9) begin miscompares++; $display("FAIL stop_bin_hold got=%0d exp=9", Bin); end
    repeat (3) step();
    vectors++; if (Busy !== 1'b0 || EN !== 1'b0) begin miscompares++; $display("FAIL stop_no_resume busy=%b en=%b exp=0/0", Busy, EN); end
    Start = 1'b1; Stop = 1'b1; step(); Start = 1'b0; Stop = 1'b0;
    vectors++; if (Busy !== 1'b0 || Sram_Rd !== 1'b0) begin miscompares++; $display("FAIL stop_beats_start busy=%b rd=%b exp=0/0", Busy, Sram_Rd); end
    repeat (4) step();
    vectors++; if (Busy !== 1'b0 || EN !== 1'b0) begin miscompares++; $display("FAIL stop_beats_start_later busy=%b en=%b exp=0/0", Busy, EN); end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    fill(4'd12);
    mem[0] = 4'd4; mem[1] = 4'd6;
    step();
    Start = 1'b1; step(); Start = 1'b0;
    repeat (7) step();
    vectors++; if (EN !== 1'b0 || Busy !== 1'b1) begin miscompares++; $display("FAIL b2b_in_gap en=%b busy=%b exp=0/1", EN, Busy); end
    Start = 1'b1; step(); Start = 1'b0;
    vectors++; if (Sram_Addr !== 4'd0 || Sram_Rd !== 1'b0) begin miscompares++; $display("FAIL b2b_ignored addr=%0d rd=%b exp=0/0", Sram_Addr, Sram_Rd); end
    step();
    vectors++; if (Sram_Rd !== 1'b1 || Sram_Addr !== 4'd1) begin miscompares++; $display("FAIL b2b_slot1_fetch rd=%b addr=%0d exp=1/1", Sram_Rd, Sram_Addr); end
    repeat (2) step();
    vectors++; if (EN !== 1'b0) begin miscompares++; $display("FAIL b2b_slot1_latch_en got=%b exp=0", EN); end
    step();
    vectors++; if (EN !== 1'b1 || Bin !== 4'd6) begin miscompares++; $display("FAIL b2b_slot1_play en=%b bin=%0d exp=1/6", EN, Bin); end
    while (Busy && n < 50) begin step(); n++; end
    vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL b2b_timeout busy=%b exp=0", Busy); end
  endtask

  initial begin
    test_reset();
    test_two_notes_end_marker();
    test_full_memory();
    test_stop();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
